// File: rtl/switch_conditioner.sv
// Synchronizes, debounces and frame-latches active-low switch inputs, with press/release strobes.
// Optional per-channel auto-repeat on held presses is enabled by defining SWITCH_CONDITIONER_REPEAT_EN.
module switch_conditioner #(
  parameter int NUM_SW          = 3,
  parameter int DEBOUNCE_CYCLES = 31500,
  parameter int CNT_W           = 15,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_RATE     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic [NUM_SW-1:0] sw_n,
  output logic [NUM_SW-1:0] sw_n_clean,
  output logic [NUM_SW-1:0] frame_sw_n,
  output logic [NUM_SW-1:0] press,
  output logic [NUM_SW-1:0] release_strobe
);

  typedef enum logic [1:0] {UP, PEND_DN, DN, PEND_UP} state_t;

  localparam logic [CNT_W-1:0] ACCEPT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [NUM_SW-1:0] sync_a;
  logic [NUM_SW-1:0] sync_s;
  logic              vsync_d;
  logic              rise;

  assign rise = vsync & ~vsync_d;

  // Frame latch samples the clean level as it stood before this edge's debouncer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a     <= '1;
      sync_s     <= '1;
      vsync_d    <= 1'b0;
      frame_sw_n <= '1;
    end else begin
      sync_a  <= sw_n;
      sync_s  <= sync_a;
      vsync_d <= vsync;
      if (rise) begin
        frame_sw_n <= sw_n_clean;
      end
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             clean_q;
    logic             press_q;
    logic             rel_q;
    logic             s;

    assign s                 = sync_s[i];
    assign sw_n_clean[i]     = clean_q;
    assign press[i]          = press_q;
    assign release_strobe[i] = rel_q;

`ifdef SWITCH_CONDITIONER_REPEAT_EN
    localparam logic [7:0] RPT_DELAY  = 8'(REPEAT_DELAY);
    localparam logic [7:0] RPT_RELOAD = 8'(REPEAT_DELAY - REPEAT_RATE);
    logic [7:0] fcnt;

    // Repeats are only generated while the channel stays in DN, so they cannot meet a release.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= UP;
        cnt     <= '0;
        clean_q <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        fcnt    <= '0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          UP: begin
            if (!s) begin
              state <= PEND_DN;
              cnt   <= ONE;
            end else begin
              cnt <= '0;
            end
          end
          PEND_DN: begin
            if (s) begin
              state <= UP;
              cnt   <= '0;
            end else if (cnt == ACCEPT) begin
              state   <= DN;
              cnt     <= '0;
              clean_q <= 1'b0;
              press_q <= 1'b1;
              fcnt    <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          DN: begin
            if (s) begin
              state <= PEND_UP;
              cnt   <= ONE;
              fcnt  <= '0;
            end else begin
              cnt <= '0;
              if (rise) begin
                if (fcnt + 8'd1 == RPT_DELAY) begin
                  press_q <= 1'b1;
                  fcnt    <= RPT_RELOAD;
                end else begin
                  fcnt <= fcnt + 8'd1;
                end
              end
            end
          end
          PEND_UP: begin
            if (!s) begin
              state <= DN;
              cnt   <= '0;
            end else if (cnt == ACCEPT) begin
              state   <= UP;
              cnt     <= '0;
              clean_q <= 1'b1;
              rel_q   <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: state <= UP;
        endcase
      end
    end
`else
    // Acceptance at DEBOUNCE_CYCLES-1 keeps the counter from ever wrapping.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= UP;
        cnt     <= '0;
        clean_q <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          UP: begin
            if (!s) begin
              state <= PEND_DN;
              cnt   <= ONE;
            end else begin
              cnt <= '0;
            end
          end
          PEND_DN: begin
            if (s) begin
              state <= UP;
              cnt   <= '0;
            end else if (cnt == ACCEPT) begin
              state   <= DN;
              cnt     <= '0;
              clean_q <= 1'b0;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          DN: begin
            if (s) begin
              state <= PEND_UP;
              cnt   <= ONE;
            end else begin
              cnt <= '0;
            end
          end
          PEND_UP: begin
            if (!s) begin
              state <= DN;
              cnt   <= '0;
            end else if (cnt == ACCEPT) begin
              state   <= UP;
              cnt     <= '0;
              clean_q <= 1'b1;
              rel_q   <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: state <= UP;
        endcase
      end
    end
`endif
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner with a short debounce time.
// Expected strobes are queued when switches are driven and retired on the cycle they are due.
module tb_switch_conditioner;

  localparam int NSW = 3;
  localparam int DB  = 4;
  localparam int LAT = 2 + DB;

  logic           clk;
  logic           reset;
  logic           vsync;
  logic [NSW-1:0] sw_n;
  logic [NSW-1:0] sw_n_clean;
  logic [NSW-1:0] frame_sw_n;
  logic [NSW-1:0] press;
  logic [NSW-1:0] release_strobe;

  switch_conditioner #(
    .NUM_SW(NSW), .DEBOUNCE_CYCLES(DB), .CNT_W(3),
    .REPEAT_DELAY(3), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .sw_n(sw_n),
    .sw_n_clean(sw_n_clean), .frame_sw_n(frame_sw_n),
    .press(press), .release_strobe(release_strobe)
  );

  typedef struct {
    int cyc;
    int ch;
    bit is_press;
  } ev_t;

  ev_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic rose   = 1'b0;
  logic vsync_last = 1'b0;
  bit   mon_en = 0;
  logic [NSW-1:0] exp_clean = '1;
  logic [NSW-1:0] exp_frame = '1;
  logic [NSW-1:0] ep;
  logic [NSW-1:0] er;
  ev_t  cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rose       <= vsync && !vsync_last;
    vsync_last <= vsync;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_event(input int c, input int ch, input bit p);
    ev_t e;
    int  pos;
    e   = '{c, ch, p};
    pos = sb_q.size();
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    sb_q.insert(pos, e);
  endtask

  task automatic applyStimulus(input int ch, input logic level, input bit expect_event);
    sw_n[ch] = level;
    if (expect_event) push_event(cyc + LAT, ch, !level);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    wait_cycles(1);
    vsync = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_clean"}, 32'(sw_n_clean), 32'h7);
    checkOutput({tag, "_frame"}, 32'(frame_sw_n), 32'h7);
    checkOutput({tag, "_press"}, 32'(press), 32'h0);
    checkOutput({tag, "_release"}, 32'(release_strobe), 32'h0);
  endtask

  // Retire due events, then compare every output against the spec-level expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      ep = '0;
      er = '0;
      if (rose) exp_frame = exp_clean;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        cur = sb_q.pop_front();
        checkOutput("sb_due", 32'(cur.cyc), 32'(cyc));
        if (cur.is_press) begin
          ep[cur.ch]        = 1'b1;
          exp_clean[cur.ch] = 1'b0;
        end else begin
          er[cur.ch]        = 1'b1;
          exp_clean[cur.ch] = 1'b1;
        end
      end
      checkOutput("press", 32'(press), 32'(ep));
      checkOutput("release", 32'(release_strobe), 32'(er));
      checkOutput("clean", 32'(sw_n_clean), 32'(exp_clean));
      checkOutput("frame", 32'(frame_sw_n), 32'(exp_frame));
    end
  end

  initial begin
    reset = 1'b0;
    vsync = 1'b0;
    sw_n  = '1;
    wait_cycles(3);
    check_reset_values("reset");
    reset = 1'b1;
    mon_en = 1;
    wait_cycles(6);

    // Clean press and release on channel 0, with a frame latch while held.
    applyStimulus(0, 1'b0, 1);
    wait_cycles(10);
    pulse_vsync();
    wait_cycles(4);
    applyStimulus(0, 1'b1, 1);
    wait_cycles(10);
    pulse_vsync();
    wait_cycles(3);

    // Bounces of 3 cycles on channel 1 must be rejected.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1'b0, 0);
      wait_cycles(3);
      applyStimulus(1, 1'b1, 0);
      wait_cycles(3);
    end
    wait_cycles(6);

    // Long hold and clean release on channel 2.
    applyStimulus(2, 1'b0, 1);
    wait_cycles(12);
    applyStimulus(2, 1'b1, 1);
    wait_cycles(10);

    // Simultaneous events on channels 0 and 1.
    applyStimulus(0, 1'b0, 1);
    applyStimulus(1, 1'b0, 1);
    wait_cycles(10);
    applyStimulus(0, 1'b1, 1);
    applyStimulus(1, 1'b1, 1);
    wait_cycles(10);

    // Acceptance coinciding with a vsync rise latches the old level.
    applyStimulus(0, 1'b0, 1);
    wait_cycles(LAT - 1);
    pulse_vsync();
    wait_cycles(2);
    checkOutput("coincide_frame_old", 32'(frame_sw_n[0]), 32'h1);
    wait_cycles(5);
    pulse_vsync();
    wait_cycles(2);
    checkOutput("coincide_frame_next", 32'(frame_sw_n[0]), 32'h0);
    applyStimulus(0, 1'b1, 1);
    wait_cycles(10);

`ifdef SWITCH_CONDITIONER_REPEAT_EN
    // Auto-repeat: held for 8 frames gives repeats on rises 3, 5 and 7.
    applyStimulus(0, 1'b0, 1);
    wait_cycles(8);
    for (int f = 1; f <= 8; f++) begin
      wait_cycles(8);
      if (f == 3 || f == 5 || f == 7) push_event(cyc + 1, 0, 1);
      pulse_vsync();
    end
    wait_cycles(4);
    applyStimulus(0, 1'b1, 1);
    wait_cycles(10);
`endif

    // Reset while channel 2 is pending, with channel 1 held and latched.
    applyStimulus(1, 1'b0, 1);
    wait_cycles(8);
    pulse_vsync();
    wait_cycles(3);
    checkOutput("pre_reset_frame", 32'(frame_sw_n), 32'h5);
    applyStimulus(2, 1'b0, 0);
    wait_cycles(4);
    mon_en = 0;
    reset  = 1'b0;
    sw_n   = '1;
    #1;
    check_reset_values("midpend");
    sb_q.delete();
    exp_clean = '1;
    exp_frame = '1;
    wait_cycles(3);
    reset  = 1'b1;
    mon_en = 1;
    wait_cycles(12);

    checkOutput("sb_drain", 32'(sb_q.size()), 32'h0);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
